// File: rtl/display_pkg.sv
// display_pkg: shared constants for the multiplexed 7-segment display.
//   NUM_DIGITS  - number of digit slots scanned
//   SEG_*       - active-low segment patterns, bit order {g,f,e,d,c,b,a}
//   SEG_BLANK   - all segments off
//   ANODE_OFF   - all digit enables off (active-low)
//   anode_sel() - active-low one-cold enable for a slot index
package display_pkg;

  localparam int unsigned NUM_DIGITS = 8;
  localparam int unsigned SLOT_W     = $clog2(NUM_DIGITS);

  typedef logic [SLOT_W-1:0] slot_t;
  typedef logic [6:0]        seg_t;

  localparam logic [7:0] ANODE_OFF = 8'hFF;
  localparam seg_t       SEG_BLANK = 7'h7F;

  localparam seg_t SEG_0 = 7'b1000000;
  localparam seg_t SEG_1 = 7'b1111001;
  localparam seg_t SEG_2 = 7'b0100100;
  localparam seg_t SEG_3 = 7'b0110000;
  localparam seg_t SEG_4 = 7'b0011001;
  localparam seg_t SEG_5 = 7'b0010010;
  localparam seg_t SEG_6 = 7'b0000010;
  localparam seg_t SEG_7 = 7'b1111000;
  localparam seg_t SEG_8 = 7'b0000000;
  localparam seg_t SEG_9 = 7'b0010000;

  function automatic logic [7:0] anode_sel(input slot_t slot);
    return ~(8'b1 << slot);
  endfunction

endpackage

// File: rtl/seg7_decode.sv
// seg7_decode: combinational BCD to active-low 7-segment decode.
//   digit - 4-bit BCD value; 10..15 decode to blank
//   seg   - active-low segments {g,f,e,d,c,b,a}
module seg7_decode
  import display_pkg::*;
(
  input  logic [3:0] digit,
  output seg_t       seg
);

  always_comb begin
    seg = SEG_BLANK;
    case (digit)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/display_scan.sv
// display_scan: time-multiplexed scan driver for an 8-digit 7-segment display.
//   clk                  - system clock, all state on rising edge
//   reset                - synchronous active-high reset
//   one_digit            - BCD value for the slot in refreshcounter
//   position_pointer_now - current slot holds the edit cursor
//   refreshcounter       - current slot index (0 = rightmost)
//   anode                - active-low digit enables, bit n = slot n
//   cathode              - active-low segments {g,f,e,d,c,b,a}
//   dp                   - active-low decimal point, blinks on the cursor slot
// Each slot lasts CLK_DIV cycles; the first GUARD cycles keep every anode off
// so the registered cathode settles on the new digit before it is lit.
module display_scan
  import display_pkg::*;
#(
  parameter int unsigned CLK_DIV     = 50000,
  parameter int unsigned GUARD       = 4,
  parameter int unsigned BLINK_TICKS = 256
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] one_digit,
  input  logic       position_pointer_now,
  output logic [2:0] refreshcounter,
  output logic [7:0] anode,
  output logic [6:0] cathode,
  output logic       dp
);

  localparam int unsigned DIV_W   = $clog2(CLK_DIV);
  localparam int unsigned GUARD_W = $clog2(GUARD + 1);
  localparam int unsigned BLINK_W = $clog2(BLINK_TICKS + 1);

  localparam logic [DIV_W-1:0]   DIV_LAST   = DIV_W'(CLK_DIV - 1);
  localparam logic [GUARD_W-1:0] GUARD_INIT = GUARD_W'(GUARD);
  localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_TICKS - 1);

  logic [DIV_W-1:0]   div_cnt;
  logic [GUARD_W-1:0] guard_cnt;
  logic [GUARD_W-1:0] guard_next;
  logic [BLINK_W-1:0] blink_cnt;
  logic               blink_on;
  logic               tick;
  slot_t              slot_next;
  seg_t               seg;

  seg7_decode u_seg7_decode (
    .digit (one_digit),
    .seg   (seg)
  );

  // Next slot/guard values are shared by the counters and the output
  // registers, so anode/cathode/dp line up with the state they describe.
  always_comb begin
    tick       = (div_cnt == DIV_LAST);
    slot_next  = refreshcounter;
    guard_next = guard_cnt;
    if (tick) begin
      slot_next  = refreshcounter + 3'd1;
      guard_next = GUARD_INIT;
    end else if (guard_cnt != '0) begin
      guard_next = guard_cnt - GUARD_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      div_cnt        <= '0;
      refreshcounter <= '0;
      guard_cnt      <= GUARD_INIT;
      blink_cnt      <= '0;
      blink_on       <= 1'b0;
      anode          <= ANODE_OFF;
      cathode        <= SEG_BLANK;
      dp             <= 1'b1;
    end else begin
      div_cnt        <= tick ? '0 : div_cnt + DIV_W'(1);
      refreshcounter <= slot_next;
      guard_cnt      <= guard_next;

      if (tick) begin
        if (blink_cnt == BLINK_LAST) begin
          blink_cnt <= '0;
          blink_on  <= ~blink_on;
        end else begin
          blink_cnt <= blink_cnt + BLINK_W'(1);
        end
      end

      if (guard_next != '0) begin
        anode   <= ANODE_OFF;
        cathode <= SEG_BLANK;
        dp      <= 1'b1;
      end else begin
        anode   <= anode_sel(slot_next);
        cathode <= seg;
        dp      <= ~(position_pointer_now & blink_on);
      end
    end
  end

endmodule

// File: tb/tb_display_scan.sv
// tb_display_scan: directed self-checking bench for display_scan
// (CLK_DIV=8, GUARD=2, BLINK_TICKS=4).
module tb_display_scan;

  localparam int unsigned CD = 8;
  localparam int unsigned GD = 2;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [3:0] one_digit = 4'd0;
  logic       position_pointer_now = 1'b0;
  logic [2:0] refreshcounter;
  logic [7:0] anode;
  logic [6:0] cathode;
  logic       dp;

  int checks = 0;
  int failures = 0;
  int k = 0;          // cycles since reset release
  bit mon_en = 1'b0;

  logic [6:0] seg_exp [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'h7F, 7'h7F,
    7'h7F, 7'h7F, 7'h7F, 7'h7F
  };

  display_scan #(.CLK_DIV(8), .GUARD(2), .BLINK_TICKS(4)) dut (
    .clk                  (clk),
    .reset                (reset),
    .one_digit            (one_digit),
    .position_pointer_now (position_pointer_now),
    .refreshcounter       (refreshcounter),
    .anode                (anode),
    .cathode              (cathode),
    .dp                   (dp)
  );

  always #5 clk = ~clk;

  // At most one anode may be low on any cycle.
  always @(negedge clk) begin
    if (mon_en) begin
      checks++;
      if ($countones(~anode) > 1 || $isunknown(anode)) begin
        failures++;
        $display("FAIL anode_onehot: got %h required at most one zero bit", anode);
      end
    end
  end

  function automatic logic [7:0] exp_anode(input int c);
    int slot = (c / CD) % 8;
    if ((c % CD) < GD) return 8'hFF;
    return ~(8'(1) << slot);
  endfunction

  task automatic cyc();
    @(negedge clk);
    k++;
  endtask

  // Leaves the bench at the negedge where reset has just been dropped; the
  // DUT then shows the reset state, i.e. cycle 0.
  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    mon_en = 1'b1;
    reset = 1'b0;
    k = 0;
  endtask

  task automatic test_reset();
    one_digit = 4'd8;
    position_pointer_now = 1'b1;
    @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    mon_en = 1'b1;
    checks++;
    if (anode !== 8'hFF) begin failures++; $display("FAIL reset_anode: got %h required ff", anode); end
    checks++;
    if (cathode !== 7'h7F) begin failures++; $display("FAIL reset_cathode: got %h required 7f", cathode); end
    checks++;
    if (dp !== 1'b1) begin failures++; $display("FAIL reset_dp: got %b required 1", dp); end
    checks++;
    if (refreshcounter !== 3'd0) begin failures++; $display("FAIL reset_slot: got %0d required 0", refreshcounter); end
    reset = 1'b0;
  endtask

  task automatic test_reset_release();
    logic [7:0] a_exp [10] = '{8'hFF, 8'hFF, 8'hFE, 8'hFE, 8'hFE, 8'hFE, 8'hFE, 8'hFE, 8'hFF, 8'hFF};
    one_digit = 4'd8;
    position_pointer_now = 1'b0;
    do_reset();
    for (int i = 0; i < 10; i++) begin
      checks++;
      if (anode !== a_exp[i]) begin
        failures++; $display("FAIL release_anode c%0d: got %h required %h", k, anode, a_exp[i]);
      end
      checks++;
      if (refreshcounter !== ((i < 8) ? 3'd0 : 3'd1)) begin
        failures++; $display("FAIL release_slot c%0d: got %0d required %0d", k, refreshcounter, (i < 8) ? 0 : 1);
      end
      if (i == 1 || i == 2) begin
        checks++;
        if (cathode !== ((i == 1) ? 7'h7F : 7'h00)) begin
          failures++; $display("FAIL release_cathode c%0d: got %b", k, cathode);
        end
      end
      cyc();
    end
  endtask

  task automatic test_wrap();
    do_reset();
    for (int i = 0; i <= 72; i++) begin
      checks++;
      if (anode !== exp_anode(k)) begin
        failures++; $display("FAIL wrap_anode c%0d: got %h required %h", k, anode, exp_anode(k));
      end
      checks++;
      if (refreshcounter !== 3'((k / CD) % 8)) begin
        failures++; $display("FAIL wrap_slot c%0d: got %0d required %0d", k, refreshcounter, (k / CD) % 8);
      end
      if (k == 63 || k == 64 || k == 66) begin
        checks++;
        if (anode !== ((k == 63) ? 8'h7F : (k == 64) ? 8'hFF : 8'hFE)) begin
          failures++; $display("FAIL wrap_edge c%0d: got %h", k, anode);
        end
      end
      cyc();
    end
  endtask

  task automatic test_decode();
    do_reset();
    for (int d = 0; d < 16; d++) begin
      while (((k + 1) % CD) < GD) cyc();
      one_digit = 4'(d);
      cyc();
      checks++;
      if (cathode !== seg_exp[d]) begin
        failures++; $display("FAIL decode_%0d: got %b required %b", d, cathode, seg_exp[d]);
      end
    end
    // guard cycles blank the cathode whatever the digit
    one_digit = 4'd8;
    while ((k % CD) != 0) cyc();
    checks++;
    if (cathode !== 7'h7F) begin failures++; $display("FAIL decode_guard: got %b required 7f", cathode); end
  endtask

  task automatic test_blink();
    logic dp_exp;
    position_pointer_now = 1'b1;
    one_digit = 4'd1;
    do_reset();
    for (int i = 0; i < 12 * 8; i++) begin
      if ((k % CD) < GD) dp_exp = 1'b1;
      else dp_exp = (((k / CD) / 4) % 2 == 1) ? 1'b0 : 1'b1;
      checks++;
      if (dp !== dp_exp) begin
        failures++; $display("FAIL blink_dp c%0d: got %b required %b", k, dp, dp_exp);
      end
      cyc();
    end
    position_pointer_now = 1'b0;
  endtask

  task automatic test_back_to_back();
    position_pointer_now = 1'b1;
    do_reset();
    while (k != 3 * 8 + 5) cyc();
    checks++;
    if (refreshcounter !== 3'd3) begin failures++; $display("FAIL midreset_pre: got %0d required 3", refreshcounter); end
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if (refreshcounter !== 3'd0) begin failures++; $display("FAIL midreset_slot: got %0d required 0", refreshcounter); end
    checks++;
    if (anode !== 8'hFF) begin failures++; $display("FAIL midreset_anode: got %h required ff", anode); end
    checks++;
    if (dp !== 1'b1) begin failures++; $display("FAIL midreset_dp: got %b required 1", dp); end
    reset = 1'b0;
    k = 0;
    cyc(); cyc();
    checks++;
    if (anode !== 8'hFE) begin failures++; $display("FAIL midreset_relit: got %h required fe", anode); end
    // reset landing on a tick cycle must not advance the slot
    while (k != 7) cyc();
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if (refreshcounter !== 3'd0) begin failures++; $display("FAIL tickreset_slot: got %0d required 0", refreshcounter); end
    checks++;
    if (anode !== 8'hFF) begin failures++; $display("FAIL tickreset_anode: got %h required ff", anode); end
    reset = 1'b0;
    position_pointer_now = 1'b0;
  endtask

  initial begin
    test_reset();
    test_reset_release();
    test_wrap();
    test_decode();
    test_blink();
    test_back_to_back();
    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
